// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-lane memory port arbiter.
//   - arb_state_e   : arbiter FSM states (IDLE, REQ, RESP)
//   - LANE0 / LANE1 : lane index constants used for grant encoding
//   - TIMEOUT_RDATA : load data returned when the watchdog fires
//   - lane_onehot() : lane index -> 2-bit one-hot vector
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  function automatic logic [1:0] lane_onehot(input logic lane);
    return (lane == LANE1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_lane_select.sv
// Lane selection for the memory port arbiter: fixed priority to lane 0 with a
// starvation guard that hands the port to lane 1 once lane 0 has been granted
// STARVE_MAX times in a row while lane 1 was waiting.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req_valid_i   : per-lane request
//   grant_en_i    : arbiter is able to accept a request this cycle
//   grant_lane_o  : selected lane index (meaningful when grant_vld_o)
//   grant_vld_o   : a grant is issued this cycle
module mem_arb_lane_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid_i,
  input  logic       grant_en_i,
  output logic       grant_lane_o,
  output logic       grant_vld_o
);

  logic [1:0] r_starve_cnt;
  logic       w_lane1_wins;

  always_comb begin
    w_lane1_wins = req_valid_i[1] && (int'(r_starve_cnt) == STARVE_MAX);
    grant_lane_o = (w_lane1_wins || !req_valid_i[0]) ? LANE1 : LANE0;
    grant_vld_o  = grant_en_i && (|req_valid_i);
  end

  // Counts lane-0 wins that happened while lane 1 was also asking; saturates
  // at 3 so it never wraps back below the threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 2'd0;
    end else if (grant_vld_o) begin
      if (grant_lane_o == LANE1) begin
        r_starve_cnt <= 2'd0;
      end else if (req_valid_i[1] && (r_starve_cnt != 2'd3)) begin
        r_starve_cnt <= r_starve_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-lane memory port arbiter. Lanes 0/1 issue load/store requests; one is
// granted at a time and forwarded to a single external memory port with at
// most one transaction outstanding. Completion is reported back to the lane
// as a one-cycle response pulse. A pipeline flush suppresses pending
// responses without aborting the external transaction.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN): a watchdog in the REQ state
// abandons a transaction after TIMEOUT_CYCLES cycles without ack, returns
// TIMEOUT_RDATA and raises the sticky timeout_err_o output.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush_i             : drop pending / in-flight responses
//   req_valid_i/we_i    : per-lane request and write flag
//   req_addr_i/wdata_i  : per-lane address and store data (lane n at n*W)
//   req_ready_o         : one-hot accept pulse (combinational in IDLE)
//   rsp_valid_o         : one-hot completion pulse
//   rsp_rdata_o         : load data for the completing lane
//   mem_*               : external memory port
//   busy_o              : arbiter not idle
//   timeout_err_o       : sticky watchdog error (MEM_ARB_TIMEOUT_EN only)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_MAX     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic [1:0]          req_valid_i,
  input  logic [1:0]          req_we_i,
  input  logic [2*ADDR_W-1:0] req_addr_i,
  input  logic [2*DATA_W-1:0] req_wdata_i,
  output logic [1:0]          req_ready_o,
  output logic [1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [ADDR_W-1:0]   mem_address_o,
  output logic [DATA_W-1:0]   mem_write_data_o,
  output logic                mem_read_en_o,
  output logic                mem_write_en_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_read_data_i,
  output logic                busy_o
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                timeout_err_o
`endif
);

  arb_state_e          r_state;
  logic                r_lane;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rd_en;
  logic                r_wr_en;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rsp_vld;
  logic                r_drop;

  logic                w_grant_en;
  logic                w_grant_lane;
  logic                w_grant_vld;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int                  TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_CNT_W-1:0] TO_LAST  = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_terr;
`endif

  // Rst is included so nothing is accepted in a cycle that is being reset.
  assign w_grant_en = (r_state == ST_IDLE) && !flush_i && !rst;

  mem_arb_lane_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_lane_select (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .grant_en_i   (w_grant_en),
    .grant_lane_o (w_grant_lane),
    .grant_vld_o  (w_grant_vld)
  );

  always_comb begin
    w_sel_we    = req_we_i[w_grant_lane];
    w_sel_addr  = (w_grant_lane == LANE1) ? req_addr_i[2*ADDR_W-1:ADDR_W]
                                          : req_addr_i[ADDR_W-1:0];
    w_sel_wdata = (w_grant_lane == LANE1) ? req_wdata_i[2*DATA_W-1:DATA_W]
                                          : req_wdata_i[DATA_W-1:0];
  end

  assign req_ready_o = w_grant_vld ? lane_onehot(w_grant_lane) : 2'b00;

  // A flush landing in the RESP cycle itself still kills the pulse.
  assign rsp_valid_o = (r_rsp_vld && !flush_i) ? lane_onehot(r_lane) : 2'b00;

  assign rsp_rdata_o      = r_rdata;
  assign mem_address_o    = r_addr;
  assign mem_write_data_o = r_wdata;
  assign mem_read_en_o    = r_rd_en;
  assign mem_write_en_o   = r_wr_en;
  assign busy_o           = (r_state != ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err_o = r_terr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lane    <= LANE0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rdata   <= '0;
      r_rsp_vld <= 1'b0;
      r_drop    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_terr    <= 1'b0;
`endif
    end else begin
      r_rsp_vld <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_drop <= 1'b0;
          if (w_grant_vld) begin
            r_lane  <= w_grant_lane;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_rd_en <= !w_sel_we;
            r_wr_en <= w_sel_we;
`ifdef MEM_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            r_state <= ST_REQ;
          end
        end

        // Strobes stay asserted until ack; a flush only marks the response
        // for suppression, the external transaction always completes.
        ST_REQ: begin
          if (flush_i) begin
            r_drop <= 1'b1;
          end
          if (mem_ack_i) begin
            r_rdata   <= r_we ? '0 : mem_read_data_i;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rsp_vld <= !(r_drop || flush_i);
            r_state   <= ST_RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_rdata   <= DATA_W'(TIMEOUT_RDATA);
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rsp_vld <= !(r_drop || flush_i);
            r_terr    <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 2;
  localparam int TMO  = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic [1:0]      req_valid_i;
  logic [1:0]      req_we_i;
  logic [2*AW-1:0] req_addr_i;
  logic [2*DW-1:0] req_wdata_i;
  logic [1:0]      req_ready_o;
  logic [1:0]      rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic [AW-1:0]   mem_address_o;
  logic [DW-1:0]   mem_write_data_o;
  logic            mem_read_en_o;
  logic            mem_write_en_o;
  logic            mem_ack_i;
  logic [DW-1:0]   mem_read_data_i;
  logic            busy_o;
`ifdef MEM_ARB_TIMEOUT_EN
  logic            timeout_err_o;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .STARVE_MAX     (SMAX),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_we_i         (req_we_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .req_ready_o      (req_ready_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .mem_address_o    (mem_address_o),
    .mem_write_data_o (mem_write_data_o),
    .mem_read_en_o    (mem_read_en_o),
    .mem_write_en_o   (mem_write_en_o),
    .mem_ack_i        (mem_ack_i),
    .mem_read_data_i  (mem_read_data_i),
    .busy_o           (busy_o)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err_o    (timeout_err_o)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level reference: phase 0 = free, 1 = transaction on the
  // external port, 2 = reporting completion.
  int            m_phase  = 0;
  logic          m_lane   = 1'b0;
  logic          m_we     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic [DW-1:0] m_rdata  = '0;
  logic          m_drop   = 1'b0;
  int            m_starve = 0;
  int            m_reqcyc = 0;
  logic          m_terr   = 1'b0;

  function automatic logic [1:0] exp_ready();
    int lane;
    if (m_phase != 0 || flush_i || req_valid_i == 2'b00) return 2'b00;
    if (req_valid_i[1] && m_starve == SMAX) lane = 1;
    else if (req_valid_i[0])                lane = 0;
    else                                    lane = 1;
    return 2'(1 << lane);
  endfunction

  function automatic logic [1:0] exp_rsp();
    if (m_phase == 2 && !m_drop && !flush_i) return m_lane ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic compare_outputs();
    logic [1:0] er;
    er = exp_rsp();
    chk("req_ready", req_ready_o, exp_ready());
    chk("rsp_valid", rsp_valid_o, er);
    if (er != 2'b00) chk("rsp_rdata", rsp_rdata_o, m_rdata);
    chk("rd_en", mem_read_en_o, (m_phase == 1) && !m_we);
    chk("wr_en", mem_write_en_o, (m_phase == 1) && m_we);
    chk("busy", busy_o, m_phase != 0);
    if (m_phase == 1) begin
      chk("mem_addr", mem_address_o, m_addr);
      chk("mem_wdata", mem_write_data_o, m_wdata);
    end
`ifdef MEM_ARB_TIMEOUT_EN
    chk("timeout_err", timeout_err_o, m_terr);
`endif
  endtask

  task automatic advance_model();
    logic [1:0] g;
    if (rst) begin
      m_phase = 0; m_starve = 0; m_drop = 0; m_lane = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_terr = 0; m_reqcyc = 0;
      return;
    end
    case (m_phase)
      0: begin
        g = exp_ready();
        if (g != 2'b00) begin
          m_lane  = g[1];
          m_we    = req_we_i[m_lane];
          m_addr  = req_addr_i[m_lane*AW +: AW];
          m_wdata = req_wdata_i[m_lane*DW +: DW];
          if (m_lane) m_starve = 0;
          else if (req_valid_i[1] && m_starve < 3) m_starve++;
          m_drop   = 0;
          m_reqcyc = 0;
          m_phase  = 1;
        end
      end
      1: begin
        if (flush_i) m_drop = 1;
        m_reqcyc++;
        if (mem_ack_i) begin
          m_rdata = m_we ? '0 : mem_read_data_i;
          m_phase = 2;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (m_reqcyc == TMO) begin
          m_rdata = 32'hDEAD_BEEF;
          m_terr  = 1;
          m_phase = 2;
        end
`endif
      end
      default: begin
        m_phase = 0;
        m_drop  = 0;
      end
    endcase
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) compare_outputs();
      advance_model();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [1:0] seq [3];
    int         n;
    rst = 1'b1; flush_i = 0; req_valid_i = 0; req_we_i = 0; mem_ack_i = 0;
    req_addr_i = '0; req_wdata_i = '0; mem_read_data_i = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_rdata", rsp_rdata_o, 0);
    chk("reset_strobes", {mem_read_en_o, mem_write_en_o}, 0);

    // Single lane-0 read, ack one cycle after accept.
    step(); req_valid_i = 2'b01; req_we_i = 2'b00; req_addr_i = {32'h0, 32'h100};
    @(negedge clk); chk("t1_ready", req_ready_o, 2'b01);
    step(); req_valid_i = 0; mem_ack_i = 1; mem_read_data_i = 32'h1234;
    @(negedge clk); chk("t1_rd_en", mem_read_en_o, 1); chk("t1_addr", mem_address_o, 32'h100);
    step(); mem_ack_i = 0;
    @(negedge clk);
    chk("t1_rsp", rsp_valid_o, 2'b01); chk("t1_rdata", rsp_rdata_o, 32'h1234);
    chk("t1_rd_off", mem_read_en_o, 0);
    step();
    @(negedge clk); chk("t1_idle", busy_o, 0);

    // Both lanes at once: lane 0 first, lane 1 write right after RESP.
    step(); req_valid_i = 2'b11; req_we_i = 2'b10;
    req_addr_i = {32'h200, 32'h300}; req_wdata_i = {32'hAA, 32'h55};
    @(negedge clk); chk("t2_first", req_ready_o, 2'b01);
    step(); req_valid_i = 2'b10; mem_ack_i = 1; mem_read_data_i = 32'hFFFF;
    @(negedge clk); chk("t2_no_grant_req", req_ready_o, 0);
    step(); mem_ack_i = 0;
    @(negedge clk); chk("t2_rsp0", rsp_valid_o, 2'b01); chk("t2_no_grant_resp", req_ready_o, 0);
    step();
    @(negedge clk); chk("t2_second", req_ready_o, 2'b10);
    step(); req_valid_i = 0; mem_ack_i = 1;
    @(negedge clk);
    chk("t2_wr_en", mem_write_en_o, 1); chk("t2_rd_en", mem_read_en_o, 0);
    chk("t2_wdata", mem_write_data_o, 32'hAA); chk("t2_addr", mem_address_o, 32'h200);
    step(); mem_ack_i = 0;
    @(negedge clk); chk("t2_rsp1", rsp_valid_o, 2'b10); chk("t2_wr_rdata", rsp_rdata_o, 0);
    step();

    // Starvation: both lanes held valid, lane 1 wins the third grant.
    req_valid_i = 2'b11; req_we_i = 2'b00; mem_ack_i = 1;
    n = 0;
    for (int c = 0; c < 15 && n < 3; c++) begin
      @(negedge clk);
      if (req_ready_o != 2'b00) begin
        seq[n] = req_ready_o;
        n++;
      end
      step();
    end
    chk("t3_grants", n, 3);
    chk("t3_g1", seq[0], 2'b01);
    chk("t3_g2", seq[1], 2'b01);
    chk("t3_g3", seq[2], 2'b10);
    req_valid_i = 0;
    step(); step();
    mem_ack_i = 0;

    // Flush during REQ: strobe held until ack, response suppressed.
    req_valid_i = 2'b01; req_we_i = 0; req_addr_i = {32'h0, 32'h440};
    @(negedge clk); chk("t4_ready", req_ready_o, 2'b01);
    step(); req_valid_i = 0; flush_i = 1;
    @(negedge clk); chk("t4_rd_a", mem_read_en_o, 1);
    step(); flush_i = 0;
    @(negedge clk); chk("t4_rd_b", mem_read_en_o, 1);
    step();
    @(negedge clk); chk("t4_rd_c", mem_read_en_o, 1);
    step(); mem_ack_i = 1; mem_read_data_i = 32'h5A5A;
    @(negedge clk); chk("t4_rd_d", mem_read_en_o, 1);
    step(); mem_ack_i = 0;
    @(negedge clk);
    chk("t4_no_rsp", rsp_valid_o, 0); chk("t4_busy", busy_o, 1); chk("t4_rd_off", mem_read_en_o, 0);
    step();
    @(negedge clk); chk("t4_idle", busy_o, 0);

    // Reset while a lane-1 write is in REQ.
    step(); req_valid_i = 2'b10; req_we_i = 2'b10;
    req_addr_i = {32'h880, 32'h0}; req_wdata_i = {32'h99, 32'h0};
    @(negedge clk); chk("t5_ready", req_ready_o, 2'b10);
    step(); req_valid_i = 0; rst = 1;
    @(negedge clk); chk("t5_wr_before", mem_write_en_o, 1);
    step(); rst = 0;
    @(negedge clk);
    chk("t5_busy", busy_o, 0); chk("t5_wr", mem_write_en_o, 0); chk("t5_rd", mem_read_en_o, 0);
    chk("t5_addr", mem_address_o, 0); chk("t5_wdata", mem_write_data_o, 0);
    chk("t5_rsp", rsp_valid_o, 0); chk("t5_rdata", rsp_rdata_o, 0); chk("t5_ready0", req_ready_o, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no ack ever arrives.
    step(); req_valid_i = 2'b01; req_we_i = 0;
    @(negedge clk); chk("t6_ready", req_ready_o, 2'b01);
    step(); req_valid_i = 0;
    for (int c = 0; c < TMO + 20; c++) begin
      @(negedge clk);
      if (rsp_valid_o != 2'b00) break;
    end
    chk("t6_rsp", rsp_valid_o, 2'b01);
    chk("t6_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    chk("t6_err", timeout_err_o, 1);
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst             = ($urandom_range(0, 149) == 0);
      flush_i         = ($urandom_range(0, 9) == 0);
      req_valid_i     = 2'($urandom_range(0, 3));
      req_we_i        = 2'($urandom_range(0, 3));
      req_addr_i      = {$urandom, $urandom};
      req_wdata_i     = {$urandom, $urandom};
      mem_read_data_i = $urandom;
      mem_ack_i       = (m_phase == 1) && ($urandom_range(0, 2) != 0);
    end

    step();
    rst = 0; flush_i = 0; req_valid_i = 0; mem_ack_i = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
